wts_channel_mixer: RTL

WTS_CHANNEL_MIXER -- requirements
Module: wts_channel_mixer

---
 rtl/wts_pkg.sv | 10 +
 rtl/wts_volume_multiplier.sv | 15 +
 rtl/wts_channel_mixer.sv | 94 +++++++++
 3 files changed

// File: rtl/wts_pkg.sv
// wts_pkg: shared widths, channel count default and FSM encoding for the channel mixer.
package wts_pkg;
    localparam int CH_NUM_DEF = 5;
    localparam int WAVE_W     = 8;
    localparam int VOL_W      = 4;
    localparam int PROD_W     = 12;
    localparam int ACC_W      = 15;
    localparam int OUT_W      = 16;
    typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;
endpackage

// File: rtl/wts_volume_multiplier.sv
// wts_volume_multiplier: combinational signed wave sample x unsigned volume.
// Ports: wave (signed sample), volume (unsigned gain), product (exact signed result).
module wts_volume_multiplier
    import wts_pkg::*;
(
    input  logic [WAVE_W-1:0] wave,
    input  logic [VOL_W-1:0]  volume,
    output logic [PROD_W-1:0] product
);
    // A zero bit is prepended so the volume stays non-negative in the signed multiply;
    // the full result range (-1920..1905) fits exactly in the low PROD_W bits.
    logic signed [WAVE_W+VOL_W:0] full;
    assign full    = $signed(wave) * $signed({1'b0, volume});
    assign product = full[PROD_W-1:0];
endmodule

// File: rtl/wts_channel_mixer.sv
// wts_channel_mixer: sums volume-scaled wave RAM samples of all channel slots in a frame.
// Ports: clk/reset (sync, active high); slot_* sequencer inputs with per-slot wave_address,
// ch_volume and ch_enable; ram_address/ram_rdata to the wave RAM (1-cycle read latency);
// sample_out (held mixed result) with a one-cycle sample_valid pulse.
module wts_channel_mixer
    import wts_pkg::*;
#(
    parameter int CH_NUM = CH_NUM_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              slot_valid,
    input  logic [2:0]        slot_channel,
    input  logic              slot_last,
    input  logic [6:0]        wave_address,
    input  logic [VOL_W-1:0]  ch_volume,
    input  logic [CH_NUM-1:0] ch_enable,
    output logic [9:0]        ram_address,
    input  logic [WAVE_W-1:0] ram_rdata,
    output logic [OUT_W-1:0]  sample_out,
    output logic              sample_valid
);
    // Zero-padded to 8 so channel indices at or above CH_NUM read as disabled.
    logic [7:0]               en_ext;
    logic                     v0, l0, en0, v1, l1, en1;
    logic [VOL_W-1:0]         vol0, vol1;
    logic [PROD_W-1:0]        product, prod_g;
    logic signed [ACC_W-1:0]  acc, acc_n, base, sum;
    logic [OUT_W-1:0]         out_n;
    logic                     sv_n;
    state_t                   state, state_n;

    assign en_ext = 8'(ch_enable);

    // ram_rdata arrives while the stage-1 control is held, so the product is formed
    // combinationally and folded into the accumulator on the same edge.
    wts_volume_multiplier u_mul (
        .wave    (ram_rdata),
        .volume  (vol1),
        .product (product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_address  <= '0;
            v0           <= 1'b0;
            l0           <= 1'b0;
            en0          <= 1'b0;
            vol0         <= '0;
            v1           <= 1'b0;
            l1           <= 1'b0;
            en1          <= 1'b0;
            vol1         <= '0;
            acc          <= '0;
            state        <= IDLE;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else begin
            ram_address  <= {slot_channel, wave_address};
            v0           <= slot_valid;
            l0           <= slot_valid & slot_last;
            en0          <= en_ext[slot_channel];
            vol0         <= ch_volume;
            v1           <= v0;
            l1           <= l0;
            en1          <= en0;
            vol1         <= vol0;
            acc          <= acc_n;
            state        <= state_n;
            sample_out   <= out_n;
            sample_valid <= sv_n;
        end
    end

    always_comb begin
        prod_g  = en1 ? product : '0;
        base    = (state == ACC) ? acc : '0;
        sum     = base + {{(ACC_W-PROD_W){prod_g[PROD_W-1]}}, prod_g};
        state_n = state;
        acc_n   = acc;
        out_n   = sample_out;
        sv_n    = 1'b0;
        if (v1) begin
            if (l1) begin
                out_n   = {sum[ACC_W-1], sum};
                sv_n    = 1'b1;
                state_n = IDLE;
            end else begin
                acc_n   = sum;
                state_n = ACC;
            end
        end
    end
endmodule
